bird_physics: RTL and testbench

//  Next-generation bird motion engine for Flappy Bird.
//  - Replaces the fixed +/-1 px/clk motion with frame-ticked signed velocity, gravity and a flap impulse.
//  - Adds ceiling clamping, floor detection and a game-state FSM.
//  - Sits between input debounce (flap), pipe collision logic (hit) and the VGA sprite renderer (x0..y1).

---
 rtl/bird_pkg.sv | 29 ++
 rtl/bird_physics_if.sv | 35 +++
 rtl/flap_edge_latch.sv | 38 +++
 rtl/bird_physics.sv | 140 ++++++++++++++
 tb/tb_bird_physics.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/bird_pkg.sv
// ============================================================================
//  Module  : bird_pkg
//  Brief   : Shared state type and default physics constants for the bird engine.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bird_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        FALL = 2'd2,
        DEAD = 2'd3
    } bird_state_t;

    localparam int DEF_N         = 10;
    localparam int DEF_BIRD_SIZE = 15;
    localparam int DEF_START_X   = 160;
    localparam int DEF_START_Y   = 240;
    localparam int DEF_SCREEN_H  = 480;
    localparam int DEF_GRAVITY   = 1;
    localparam int DEF_FLAP_IMP  = 6;
    localparam int DEF_MAX_FALL  = 8;
    localparam int DEF_VEL_W     = 6;

endpackage

`default_nettype wire

// File: rtl/bird_physics_if.sv
// ============================================================================
//  Module  : bird_physics_if
//  Brief   : Control inputs and sprite/status outputs of the bird engine.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface bird_physics_if #(
    parameter int N     = 10,
    parameter int VEL_W = 6
);
    logic                    tick;
    logic                    flap;
    logic                    start;
    logic                    hit;
    logic [N-1:0]            x0;
    logic [N-1:0]            x1;
    logic [N-1:0]            y0;
    logic [N-1:0]            y1;
    logic signed [VEL_W-1:0] vel;
    logic                    playing;
    logic                    dead;

    modport master (
        output tick, flap, start, hit,
        input  x0, x1, y0, y1, vel, playing, dead
    );

    modport slave (
        input  tick, flap, start, hit,
        output x0, x1, y0, y1, vel, playing, dead
    );
endinterface

`default_nettype wire

// File: rtl/flap_edge_latch.sv
// ============================================================================
//  Module  : flap_edge_latch
//  Brief   : Flap rising-edge detector with a pending latch cleared by clr.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module flap_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic flap,
    input  logic clr,
    output logic flap_req
);
    logic flap_q, flap_d;
    logic pend_q, pend_d;
    logic flap_rise;

    // An edge arriving with clr still counts for this cycle's consumer.
    always_comb begin
        flap_rise = flap & ~flap_q;
        flap_req  = pend_q | flap_rise;
        flap_d    = flap;
        pend_d    = clr ? 1'b0 : flap_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flap_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            flap_q <= flap_d;
            pend_q <= pend_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/bird_physics.sv
// ============================================================================
//  Module  : bird_physics
//  Brief   : Frame-ticked bird motion with gravity, flap impulse and game FSM.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bird_physics
    import bird_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int BIRD_SIZE = DEF_BIRD_SIZE,
    parameter int START_X   = DEF_START_X,
    parameter int START_Y   = DEF_START_Y,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int GRAVITY   = DEF_GRAVITY,
    parameter int FLAP_IMP  = DEF_FLAP_IMP,
    parameter int MAX_FALL  = DEF_MAX_FALL,
    parameter int VEL_W     = DEF_VEL_W
) (
    input  logic          clk,
    input  logic          reset,
    bird_physics_if.slave bus
);
    localparam int HALF    = BIRD_SIZE / 2;
    localparam int SPAN    = 2 * HALF;
    localparam int FLOOR_Y = SCREEN_H - 1;

    localparam logic [N-1:0]            c_x0        = N'(START_X - HALF);
    localparam logic [N-1:0]            c_x1        = N'(START_X + HALF);
    localparam logic [N-1:0]            c_y0_init   = N'(START_Y - HALF);
    localparam logic [N-1:0]            c_y1_init   = N'(START_Y - HALF + SPAN);
    localparam logic [N-1:0]            c_span      = N'(SPAN);
    localparam logic [N-1:0]            c_floor_y0  = N'(FLOOR_Y - SPAN);
    localparam logic [N-1:0]            c_floor_y1  = N'(FLOOR_Y);
    localparam logic [N+1:0]            c_span_w    = (N+2)'(SPAN);
    localparam logic [N+1:0]            c_floor_w   = (N+2)'(FLOOR_Y);
    localparam logic signed [VEL_W-1:0] c_flap_vel  = VEL_W'(-FLAP_IMP);
    localparam logic signed [VEL_W-1:0] c_max_fall  = VEL_W'(MAX_FALL);
    localparam logic signed [VEL_W:0]   c_grav_w    = (VEL_W+1)'(GRAVITY);
    localparam logic signed [VEL_W:0]   c_max_w     = (VEL_W+1)'(MAX_FALL);

    bird_state_t             state_q, state_d;
    logic [N-1:0]            y0_q, y0_d, y1_q, y1_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;

    logic                    flap_req;
    logic                    reload;
    logic                    step;
    logic                    landed;
    logic signed [VEL_W:0]   vel_ext, vel_grav;
    logic signed [VEL_W-1:0] vel_fall, vel_next;
    logic [N+1:0]            ny, ny_bottom;

    flap_edge_latch u_flap (
        .clk      (clk),
        .reset    (reset),
        .flap     (bus.flap),
        .clr      (bus.tick | reload),
        .flap_req (flap_req)
    );

    // ny is two bits wider than y0 so the sign bit flags a ceiling overshoot.
    always_comb begin
        reload    = (state_q == DEAD) & bus.start;
        step      = bus.tick & (((state_q == FLY) & ~bus.hit) | (state_q == FALL));
        vel_ext   = {vel_q[VEL_W-1], vel_q};
        vel_grav  = vel_ext + c_grav_w;
        vel_fall  = (vel_grav > c_max_w) ? c_max_fall : vel_grav[VEL_W-1:0];
        vel_next  = ((state_q == FLY) & flap_req) ? c_flap_vel : vel_fall;
        ny        = {2'b00, y0_q} + {{(N+2-VEL_W){vel_q[VEL_W-1]}}, vel_q};
        ny_bottom = ny + c_span_w;
        landed    = step & ~ny[N+1] & (ny_bottom >= c_floor_w);
    end

    always_comb begin
        y0_d  = y0_q;
        y1_d  = y1_q;
        vel_d = vel_q;
        if (reload) begin
            y0_d  = c_y0_init;
            y1_d  = c_y1_init;
            vel_d = '0;
        end else if ((state_q == IDLE) & bus.start) begin
            vel_d = '0;
        end else if (step) begin
            if (ny[N+1]) begin
                y0_d  = '0;
                y1_d  = c_span;
                vel_d = '0;
            end else if (landed) begin
                y0_d  = c_floor_y0;
                y1_d  = c_floor_y1;
                vel_d = '0;
            end else begin
                y0_d  = ny[N-1:0];
                y1_d  = ny_bottom[N-1:0];
                vel_d = vel_next;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FLY;
            FLY:     if (bus.hit) state_d = FALL;
                     else if (landed) state_d = DEAD;
            FALL:    if (landed) state_d = DEAD;
            DEAD:    if (bus.start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            y0_q    <= c_y0_init;
            y1_q    <= c_y1_init;
            vel_q   <= '0;
        end else begin
            state_q <= state_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            vel_q   <= vel_d;
        end
    end

    always_comb begin
        bus.playing = (state_q == FLY);
        bus.dead    = (state_q == DEAD);
        bus.x0      = c_x0;
        bus.x1      = c_x1;
        bus.y0      = y0_q;
        bus.y1      = y1_q;
        bus.vel     = vel_q;
    end
endmodule

`default_nettype wire

// File: tb/tb_bird_physics.sv
// ============================================================================
//  Module  : tb_bird_physics
//  Brief   : Directed bench for bird_physics with an integer reference model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bird_physics;
    localparam int START_Y0 = 233;
    localparam int SPAN     = 14;
    localparam int FLOOR_Y  = 479;
    localparam int FLAP_V   = -6;
    localparam int MAX_V    = 8;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    bird_physics_if #(.N(10), .VEL_W(6)) bif ();

    bird_physics dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers and a game-phase enum of its own.
    typedef enum int {P_WAIT, P_PLAY, P_DROP, P_OVER} phase_t;
    phase_t m_phase;
    int     m_y, m_v;
    bit     m_pend, m_prev, m_valid;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_update();
        bit req;
        int ny, nv;
        req = m_pend | (bif.flap & ~m_prev);
        if (reset) begin
            m_y = START_Y0; m_v = 0; m_phase = P_WAIT;
            m_pend = 0; m_prev = 0; m_valid = 1;
        end else begin
            m_prev = bif.flap;
            m_pend = bif.tick ? 1'b0 : req;
            if (m_phase == P_OVER) begin
                if (bif.start) begin
                    m_y = START_Y0; m_v = 0; m_phase = P_WAIT; m_pend = 0;
                end
            end else if (m_phase == P_WAIT) begin
                if (bif.start) m_phase = P_PLAY;
            end else if (m_phase == P_PLAY && bif.hit) begin
                m_phase = P_DROP;
            end else if (bif.tick) begin
                nv = (m_phase == P_PLAY && req) ? FLAP_V : ((m_v + 1 > MAX_V) ? MAX_V : m_v + 1);
                ny = m_y + m_v;
                if (ny < 0) begin
                    m_y = 0; m_v = 0;
                end else if (ny + SPAN >= FLOOR_Y) begin
                    m_y = FLOOR_Y - SPAN; m_v = 0; m_phase = P_OVER;
                end else begin
                    m_y = ny; m_v = nv;
                end
            end
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge and held for one cycle.
    task automatic step(input logic t, input logic s, input logic h, input logic r);
        bif.tick = t; bif.start = s; bif.hit = h; reset = r;
        @(posedge clk);
        model_update();
        #1;
        bif.tick = 1'b0; bif.start = 1'b0; bif.hit = 1'b0; reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("y0",      int'(bif.y0), m_y);
                check("y1",      int'(bif.y1), m_y + SPAN);
                check("vel",     int'(bif.vel), m_v);
                check("x0",      int'(bif.x0), 153);
                check("x1",      int'(bif.x1), 167);
                check("playing", int'(bif.playing), int'(m_phase == P_PLAY));
                check("dead",    int'(bif.dead), int'(m_phase == P_OVER));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0; m_valid = 0;
        m_y = 0; m_v = 0; m_phase = P_WAIT; m_pend = 0; m_prev = 0;
        bif.tick = 0; bif.flap = 0; bif.start = 0; bif.hit = 0; reset = 1;
        @(negedge clk);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Idle: ticks must not move the bird.
        repeat (3) begin step(1, 0, 0, 0); step(0, 0, 0, 0); end
        check("idle_y0", int'(bif.y0), 233);
        check("idle_y1", int'(bif.y1), 247);
        check("idle_vel", int'(bif.vel), 0);
        check("idle_playing", int'(bif.playing), 0);

        // Gravity from rest.
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        check("g1_y0", int'(bif.y0), 233); check("g1_vel", int'(bif.vel), 1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("g2_y0", int'(bif.y0), 234); check("g2_vel", int'(bif.vel), 2);
        step(1, 0, 0, 0);
        check("g3_y0", int'(bif.y0), 236); check("g3_vel", int'(bif.vel), 3);

        // Flap edge two cycles ahead of the tick, then held level.
        bif.flap = 1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("flap_y0", int'(bif.y0), 239); check("flap_vel", int'(bif.vel), -6);
        step(1, 0, 0, 0);
        check("hold_y0", int'(bif.y0), 233); check("hold_vel", int'(bif.vel), -5);
        step(1, 0, 0, 0);
        check("hold2_y0", int'(bif.y0), 228);
        bif.flap = 0;
        step(0, 1, 0, 0);
        bif.flap = 1;
        step(1, 0, 0, 0);
        check("coinc_y0", int'(bif.y0), 224); check("coinc_vel", int'(bif.vel), -6);
        bif.flap = 0;

        // Free fall to saturation.
        repeat (16) step(1, 0, 0, 0);
        check("sat_y0", int'(bif.y0), 247); check("sat_vel", int'(bif.vel), 8);
        step(1, 0, 0, 0);
        check("sat2_y0", int'(bif.y0), 255); check("sat2_vel", int'(bif.vel), 8);

        // Floor.
        for (int i = 0; i < 60 && !bif.dead; i++) step(1, 0, 0, 0);
        check("floor_dead", int'(bif.dead), 1);
        check("floor_y0", int'(bif.y0), 465); check("floor_y1", int'(bif.y1), 479);

        // Dead is frozen; start reloads.
        bif.flap = 1;
        step(1, 0, 1, 0);
        bif.flap = 0;
        step(1, 0, 0, 0);
        check("dead_frozen_y0", int'(bif.y0), 465);
        step(0, 1, 0, 0);
        check("reload_y0", int'(bif.y0), 233);
        check("reload_dead", int'(bif.dead), 0);
        check("reload_playing", int'(bif.playing), 0);

        // Ceiling via repeated flaps.
        step(0, 1, 0, 0);
        for (int i = 0; i < 60; i++) begin
            bif.flap = 1; step(1, 0, 0, 0);
            bif.flap = 0; step(0, 0, 0, 0);
            if (bif.y0 == 0) break;
        end
        check("ceil_y0", int'(bif.y0), 0); check("ceil_vel", int'(bif.vel), 0);
        check("ceil_playing", int'(bif.playing), 1);
        bif.flap = 1; step(1, 0, 0, 0);
        check("ceil_flap_vel", int'(bif.vel), -6);
        bif.flap = 0; step(1, 1, 0, 0);
        check("ceil2_y0", int'(bif.y0), 0);

        // Hit beats tick; flaps ignored while falling.
        repeat (3) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("hit_playing", int'(bif.playing), 0);
        check("hit_dead", int'(bif.dead), 0);
        bif.flap = 1; step(1, 0, 0, 0);
        bif.flap = 0; step(0, 0, 0, 0);
        bif.flap = 1; step(1, 0, 0, 0);
        bif.flap = 0;
        repeat (4) step(1, 0, 0, 0);

        // Reset mid-fall.
        step(0, 0, 0, 1);
        check("rst_y0", int'(bif.y0), 233); check("rst_vel", int'(bif.vel), 0);
        check("rst_playing", int'(bif.playing), 0);
        step(0, 1, 0, 0);
        bif.flap = 1; step(1, 0, 0, 0);
        bif.flap = 0;
        for (int i = 0; i < 80 && !bif.dead; i++) step(1, 0, (i == 5) ? 1'b1 : 1'b0, 0);
        check("fall_dead", int'(bif.dead), 1);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
